comma_aligner: RTL and testbench

COMMA_ALIGNER -- requirements
Module: comma_aligner

---
 rtl/comma_aligner.sv | 181 ++++++++++++++++++
 tb/tb_comma_aligner.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/comma_aligner.sv
// comma_aligner: recovers 10b symbol boundaries from a serial bit stream by
// hunting for K28.5 commas, then emits aligned symbols to an 8b/10b decoder.
// States: HUNT (no phase), ALIGNED (phase known, not yet trusted), LOCKED.
// Optional feature: define COMMA_ALIGNER_STATS_EN to add o_Realign_Cnt, a
// saturating 8-bit count of realignment pulses.
module comma_aligner #(
    parameter int LOCK_CNT = 3,
    parameter int LOSS_CNT = 4
) (
    input  logic       i_Clk,
    input  logic       i_Rst_n,
    input  logic       i_Ser_Data,
    input  logic       i_Bit_Valid,
    output logic [9:0] o_Sym,
    output logic       o_Sym_Valid,
    output logic       o_Is_Comma,
    output logic       o_Locked,
    output logic       o_Realign,
`ifdef COMMA_ALIGNER_STATS_EN
    output logic [7:0] o_Realign_Cnt,
`endif
    output logic [1:0] o_Dbg_State
);

    // Bit stream: one bit per cycle where i_Bit_Valid=1; i_Ser_Data is
    // ignored otherwise. Symbol stream: o_Sym is valid in the single cycle
    // o_Sym_Valid=1 and holds its value in between; there is no back-pressure.

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_ALIGNED = 2'd1,
        ST_LOCKED  = 2'd2
    } state_e;

    localparam logic [9:0] K28_5_NEG = 10'b0011111010;
    localparam logic [9:0] K28_5_POS = 10'b1100000101;
    localparam logic [3:0] LOCK_V    = 4'(LOCK_CNT);
    localparam logic [3:0] LOSS_V    = 4'(LOSS_CNT);

    state_e     state_q, state_d;
    logic [9:0] win_q, win_d;
    logic [3:0] phase_q, phase_d;
    logic [3:0] good_q, good_d;
    logic [3:0] miss_q, miss_d;
    logic [9:0] sym_q, sym_d;
    logic       sym_valid_q, sym_valid_d;
    logic       is_comma_q, is_comma_d;
    logic       realign_q, realign_d;

    logic [9:0] shift_win;
    logic       comma;
    logic       boundary;
    logic [3:0] phase_nxt;
    logic [3:0] good_inc;
    logic [3:0] miss_inc;
    logic       emit;
    logic       do_realign;

    // The window includes the bit being sampled this cycle.
    assign shift_win = {win_q[8:0], i_Ser_Data};
    assign comma     = (shift_win == K28_5_NEG) || (shift_win == K28_5_POS);
    // Boundary: this bit moves phase to 9, i.e. it completes a symbol.
    assign boundary  = (phase_q == 4'd8);
    assign phase_nxt = (phase_q == 4'd9) ? 4'd0 : phase_q + 4'd1;
    assign good_inc  = (good_q == 4'd15) ? 4'd15 : good_q + 4'd1;
    assign miss_inc  = (miss_q == 4'd15) ? 4'd15 : miss_q + 4'd1;

    // Next-state logic: alignment FSM, counters and symbol capture.
    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        phase_d     = phase_q;
        good_d      = good_q;
        miss_d      = miss_q;
        sym_d       = sym_q;
        sym_valid_d = 1'b0;
        is_comma_d  = is_comma_q;
        realign_d   = 1'b0;
        emit        = 1'b0;
        do_realign  = 1'b0;

        if (i_Bit_Valid) begin
            win_d   = shift_win;
            phase_d = phase_nxt;
            unique case (state_q)
                ST_HUNT: begin
                    if (comma) do_realign = 1'b1;
                end
                ST_ALIGNED: begin
                    if (boundary) begin
                        emit = 1'b1;
                        if (comma) begin
                            good_d = good_inc;
                            if (good_inc >= LOCK_V) begin
                                state_d = ST_LOCKED;
                                miss_d  = 4'd0;
                            end
                        end
                    end else if (comma) begin
                        do_realign = 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (boundary) begin
                        emit = 1'b1;
                        if (comma) miss_d = 4'd0;
                    end else if (comma) begin
                        // Off-phase commas are tolerated until LOSS_CNT of them.
                        miss_d = miss_inc;
                        if (miss_inc >= LOSS_V) do_realign = 1'b1;
                    end
                end
                default: state_d = ST_HUNT;
            endcase

            // Realignment makes the current bit the last bit of a symbol.
            if (do_realign) begin
                phase_d   = 4'd9;
                good_d    = 4'd1;
                miss_d    = 4'd0;
                realign_d = 1'b1;
                emit      = 1'b1;
                state_d   = ((state_q == ST_HUNT) && (LOCK_CNT == 1)) ? ST_LOCKED : ST_ALIGNED;
            end

            if (emit) begin
                sym_valid_d = 1'b1;
                sym_d       = shift_win;
                is_comma_d  = comma;
            end
        end
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q     <= ST_HUNT;
            win_q       <= '0;
            phase_q     <= '0;
            good_q      <= '0;
            miss_q      <= '0;
            sym_q       <= '0;
            sym_valid_q <= 1'b0;
            is_comma_q  <= 1'b0;
            realign_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            phase_q     <= phase_d;
            good_q      <= good_d;
            miss_q      <= miss_d;
            sym_q       <= sym_d;
            sym_valid_q <= sym_valid_d;
            is_comma_q  <= is_comma_d;
            realign_q   <= realign_d;
        end
    end

`ifdef COMMA_ALIGNER_STATS_EN
    logic [7:0] realign_cnt_q;

    // Saturating count of realignment pulses.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            realign_cnt_q <= '0;
        end else if (realign_d && (realign_cnt_q != 8'hFF)) begin
            realign_cnt_q <= realign_cnt_q + 8'd1;
        end
    end

    assign o_Realign_Cnt = realign_cnt_q;
`endif

    assign o_Sym       = sym_q;
    assign o_Sym_Valid = sym_valid_q;
    assign o_Is_Comma  = is_comma_q;
    assign o_Realign   = realign_q;
    assign o_Locked    = (state_q == ST_LOCKED);
    assign o_Dbg_State = state_q;

endmodule

// File: tb/tb_comma_aligner.sv
// Testbench for comma_aligner: random and directed serial streams checked
// against a bit-history reference model through an expected-symbol queue.
module tb_comma_aligner;

  localparam int LOCK_CNT = 3;
  localparam int LOSS_CNT = 4;
  localparam int S_HUNT = 0, S_ALIGNED = 1, S_LOCKED = 2;
  localparam logic [9:0] K_NEG = 10'b0011111010;
  localparam logic [9:0] K_POS = 10'b1100000101;
  localparam logic [9:0] D21_5 = 10'b1010101010;

  // ---------------- clock / reset ----------------
  logic i_Clk = 1'b0;
  logic i_Rst_n = 1'b0;
  logic i_Ser_Data = 1'b0;
  logic i_Bit_Valid = 1'b0;
  logic [9:0] o_Sym;
  logic o_Sym_Valid, o_Is_Comma, o_Locked, o_Realign;
  logic [1:0] o_Dbg_State;
`ifdef COMMA_ALIGNER_STATS_EN
  logic [7:0] o_Realign_Cnt;
`endif

  always #5 i_Clk = ~i_Clk;

  comma_aligner #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT)) dut (
    .i_Clk(i_Clk),
    .i_Rst_n(i_Rst_n),
    .i_Ser_Data(i_Ser_Data),
    .i_Bit_Valid(i_Bit_Valid),
    .o_Sym(o_Sym),
    .o_Sym_Valid(o_Sym_Valid),
    .o_Is_Comma(o_Is_Comma),
    .o_Locked(o_Locked),
    .o_Realign(o_Realign),
`ifdef COMMA_ALIGNER_STATS_EN
    .o_Realign_Cnt(o_Realign_Cnt),
`endif
    .o_Dbg_State(o_Dbg_State)
  );

  // ---------------- scoreboard state ----------------
  logic [11:0] exp_q[$];   // {realign, is_comma, sym}
  time exp_t[$];           // time at which the strobe must be visible
  int n_vec = 0;
  int n_fail = 0;
  int seen_realign = 0;
  int gap_lo = 0, gap_hi = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Alignment is described by the index of the bit that closed the last
  // aligned symbol; a bit is a boundary when it is a whole number of
  // symbols after that index.
  bit hist[$];
  int m_state, m_good, m_miss, m_n, m_align, m_realigns;

  task automatic model_reset();
    hist.delete();
    m_state = S_HUNT; m_good = 0; m_miss = 0; m_n = 0; m_align = 0;
  endtask

  task automatic model_bit(input bit b);
    logic [9:0] win;
    bit comma, emit, realign;
    hist.push_back(b);
    if (hist.size() > 10) void'(hist.pop_front());
    win = '0;
    foreach (hist[i]) win = {win[8:0], hist[i]};
    m_n++;
    comma = (win == K_NEG) || (win == K_POS);
    emit = 0;
    realign = 0;
    if (m_state == S_HUNT) begin
      if (comma) realign = 1;
    end else if (((m_n - m_align) % 10) == 0) begin
      emit = 1;
      if (comma) begin
        if (m_state == S_ALIGNED) begin
          m_good = (m_good < 15) ? m_good + 1 : 15;
          if (m_good >= LOCK_CNT) begin m_state = S_LOCKED; m_miss = 0; end
        end else begin
          m_miss = 0;
        end
      end
    end else if (comma) begin
      if (m_state == S_ALIGNED) realign = 1;
      else begin
        m_miss = (m_miss < 15) ? m_miss + 1 : 15;
        if (m_miss >= LOSS_CNT) realign = 1;
      end
    end
    if (realign) begin
      m_state = (m_state == S_HUNT && LOCK_CNT == 1) ? S_LOCKED : S_ALIGNED;
      m_align = m_n; m_good = 1; m_miss = 0; emit = 1;
      m_realigns++;
    end
    if (emit) begin
      exp_q.push_back({realign, comma, win});
      exp_t.push_back($time + 5);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_bit(input bit b);
    @(negedge i_Clk);
    i_Bit_Valid = 1'b1;
    i_Ser_Data = b;
    @(posedge i_Clk);
    model_bit(b);
    #1;
    i_Bit_Valid = 1'b0;
    i_Ser_Data = 1'($urandom);
    repeat ($urandom_range(gap_lo, gap_hi)) @(posedge i_Clk);
    if (gap_hi > 0) #1;
  endtask

  task automatic drive_sym(input logic [9:0] w);
    for (int i = 9; i >= 0; i--) drive_bit(w[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge i_Clk);
    #1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge i_Clk) begin
    if (i_Rst_n) begin
      check("locked", {31'd0, o_Locked}, {31'd0, m_state == S_LOCKED});
      if (o_Sym_Valid) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_fail++;
          $display("FAIL unexpected_strobe: got sym %h, expected no strobe at %0t", o_Sym, $time);
        end else begin
          logic [11:0] e;
          time t;
          e = exp_q.pop_front();
          t = exp_t.pop_front();
          check("sym", {22'd0, o_Sym}, {22'd0, e[9:0]});
          check("is_comma", {31'd0, o_Is_Comma}, {31'd0, e[10]});
          check("realign", {31'd0, o_Realign}, {31'd0, e[11]});
          check("strobe_time", 32'($time), 32'(t));
        end
        if (o_Realign) seen_realign++;
      end else begin
        if (o_Realign) begin
          n_vec++; n_fail++;
          $display("FAIL stray_realign: got pulse, expected none at %0t", $time);
        end
        if (exp_t.size() > 0 && exp_t[0] < $time) begin
          n_vec++; n_fail++;
          $display("FAIL missing_strobe: got none, expected sym %h by %0t", exp_q[0][9:0], exp_t[0]);
          void'(exp_q.pop_front());
          void'(exp_t.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit parity;
    model_reset();
    m_realigns = 0;
    repeat (3) @(posedge i_Clk);
    #1;
    check("rst_sym", {22'd0, o_Sym}, 32'd0);
    check("rst_valid", {31'd0, o_Sym_Valid}, 32'd0);
    check("rst_comma", {31'd0, o_Is_Comma}, 32'd0);
    check("rst_locked", {31'd0, o_Locked}, 32'd0);
    check("rst_realign", {31'd0, o_Realign}, 32'd0);
    check("rst_state", {30'd0, o_Dbg_State}, 32'd0);
    @(negedge i_Clk);
    i_Rst_n = 1'b1;

    // Five RD- commas then D21.5: acquire, lock on the third comma.
    for (int k = 1; k <= 5; k++) begin
      drive_sym(K_NEG);
      if (k == 1) begin
        check("first_realign", {31'd0, o_Realign}, 32'd1);
        check("first_is_comma", {31'd0, o_Is_Comma}, 32'd1);
      end
      if (k == 2) check("locked_after_2", {31'd0, o_Locked}, 32'd0);
      if (k == 3) check("locked_after_3", {31'd0, o_Locked}, 32'd1);
    end
    drive_sym(D21_5);
    check("d21_5_valid", {31'd0, o_Sym_Valid}, 32'd1);
    check("d21_5_sym", {22'd0, o_Sym}, 32'h2AA);
    idle(3);

    // One slipped bit: three off-phase commas tolerated, fourth realigns.
    drive_bit(1'b0);
    for (int k = 1; k <= 6; k++) begin
      drive_sym(K_NEG);
      if (k <= 3) begin
        check("slip_no_realign", {31'd0, o_Realign}, 32'd0);
        check("slip_still_locked", {31'd0, o_Locked}, 32'd1);
      end
      if (k == 4) begin
        check("slip_realign", {31'd0, o_Realign}, 32'd1);
        check("slip_unlocked", {31'd0, o_Locked}, 32'd0);
      end
      if (k == 6) check("slip_relocked", {31'd0, o_Locked}, 32'd1);
    end

    // Bit-valid toggling 1/0: strobes 20 cycles apart, lock held.
    gap_lo = 1; gap_hi = 1;
    for (int k = 0; k < 4; k++) begin
      drive_sym(K_POS);
      drive_sym(D21_5);
    end
    check("toggle_locked", {31'd0, o_Locked}, 32'd1);
    gap_lo = 0; gap_hi = 0;

    // Random junk then alternating-disparity commas.
    repeat (7) drive_bit(1'($urandom));
    parity = 0;
    for (int k = 0; k < 8; k++) begin
      drive_sym(parity ? K_POS : K_NEG);
      parity = ~parity;
    end

    // Random mix of commas, data, slips and irregular bit-valid gaps.
    gap_lo = 0; gap_hi = 2;
    for (int k = 0; k < 40; k++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 5) begin
        drive_sym(parity ? K_POS : K_NEG);
        parity = ~parity;
      end else if (r < 8) begin
        drive_sym(10'($urandom));
      end else if (r == 8) begin
        repeat ($urandom_range(1, 3)) drive_bit(1'($urandom));
      end else begin
        idle($urandom_range(1, 5));
      end
    end
    gap_lo = 0; gap_hi = 0;

    // Reset mid-symbol while locked: outputs clear before the next edge.
    repeat (8) drive_sym(K_NEG);
    check("pre_reset_locked", {31'd0, o_Locked}, 32'd1);
    repeat (6) drive_bit(1'b1);
    #2;
    i_Rst_n = 1'b0;
    model_reset();
    #1;
    check("async_sym", {22'd0, o_Sym}, 32'd0);
    check("async_valid", {31'd0, o_Sym_Valid}, 32'd0);
    check("async_comma", {31'd0, o_Is_Comma}, 32'd0);
    check("async_locked", {31'd0, o_Locked}, 32'd0);
    check("async_realign", {31'd0, o_Realign}, 32'd0);
    check("async_state", {30'd0, o_Dbg_State}, 32'd0);
    idle(2);
    @(negedge i_Clk);
    i_Rst_n = 1'b1;
    repeat (3) drive_sym(D21_5);
    check("hunt_after_reset", {30'd0, o_Dbg_State}, 32'd0);
    drive_sym(K_POS);
    check("reacquire_realign", {31'd0, o_Realign}, 32'd1);

    // Realignment storm: each comma arrives one bit late.
    for (int k = 0; k < 300; k++) begin
      drive_bit(1'b0);
      drive_sym(K_NEG);
    end
    idle(3);
    check("realign_pulses", 32'(seen_realign), 32'(m_realigns));
`ifdef COMMA_ALIGNER_STATS_EN
    check("realign_cnt", {24'd0, o_Realign_Cnt}, 32'd255);
`endif

    check("drain", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
